// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types and defaults for the fetch sequencer.
// State encodings, widths and fetch latency.
package fetch_seq_ctrl_pkg;

   localparam int PC_W   = 16;
   localparam int CNT_W  = 8;
   localparam int FE_LAT = 2;

   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_RUN  = 2'd1,
      S_LOOP = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] cnt_init(
      input logic [CNT_W-1:0] c
   );
      return (c == '0) ? CNT_W'(1) : c;
   endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Control/status bundle between the fetch sequencer
// and its environment (decode, fetch, loop setup).
interface fetch_seq_ctrl_if;
   import fetch_seq_ctrl_pkg::*;

   logic             start;
   logic [PC_W-1:0]  start_pc;
   logic             halt;
   logic             br_valid;
   logic [PC_W-1:0]  br_target;
   logic             loop_cfg;
   logic [PC_W-1:0]  loop_start;
   logic [PC_W-1:0]  loop_end;
   logic [CNT_W-1:0] loop_count;
   logic             Loop;
   logic [PC_W-1:0]  PC_in;
   logic             id_valid;
   logic             running;
   logic             loop_active;
   logic [CNT_W-1:0] loop_remain;

   modport master (
      input  start, start_pc, halt,
      input  br_valid, br_target,
      input  loop_cfg, loop_start,
      input  loop_end, loop_count,
      output Loop, PC_in, id_valid,
      output running, loop_active,
      output loop_remain
   );

   modport slave (
      output start, start_pc, halt,
      output br_valid, br_target,
      output loop_cfg, loop_start,
      output loop_end, loop_count,
      input  Loop, PC_in, id_valid,
      input  running, loop_active,
      input  loop_remain
   );

endinterface

// File: rtl/fe_valid_pipe.sv
// Valid tags following fetches through the fetch pipe;
// clr squashes every slot in flight.
module fe_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic issue_i,
   output logic valid_o
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;

   always_comb begin
      v_d    = '0;
      v_d[0] = clr ? 1'b0 : issue_i;
      for (int i = 1; i < DEPTH; i++) begin
         v_d[i] = clr ? 1'b0 : v_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v_q <= '0;
      else     v_q <= v_d;
   end

   assign valid_o = v_q[DEPTH-1];

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: PC generation, redirects, halts
// and a single zero-overhead hardware loop.
module fetch_seq_ctrl
   import fetch_seq_ctrl_pkg::*;
(
   input logic         CLOCK_50,
   input logic         reset,
   fetch_seq_ctrl_if.master bus
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             loop_q;
   logic             act_q, act_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [PC_W-1:0]  ls_q, ls_d;
   logic [PC_W-1:0]  le_q, le_d;
   logic             clr;
   logic             issue;
   logic             cfg_ok;

   assign issue  = (state_q != S_HALT);
   assign cfg_ok = bus.loop_cfg && !act_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      act_d   = act_q;
      rem_d   = rem_q;
      ls_d    = ls_q;
      le_d    = le_q;
      clr     = 1'b0;
      unique case (state_q)
         S_HALT: begin
            if (cfg_ok) begin
               act_d = 1'b1;
               rem_d = cnt_init(bus.loop_count);
               ls_d  = bus.loop_start;
               le_d  = bus.loop_end;
            end
            if (bus.start) begin
               state_d = (act_q || cfg_ok) ? S_LOOP : S_RUN;
               pc_d    = bus.start_pc;
            end
         end
         default: begin
            if (bus.halt) begin
               state_d = S_HALT;
               clr     = 1'b1;
               act_d   = 1'b0;
               rem_d   = '0;
            end else if (bus.br_valid) begin
               state_d = S_RUN;
               pc_d    = bus.br_target;
               clr     = 1'b1;
               act_d   = 1'b0;
               rem_d   = '0;
            end else if (state_q == S_LOOP
                         && pc_q == le_q) begin
               // last body slot: rewind or fall through
               if (rem_q > CNT_W'(1)) begin
                  pc_d  = ls_q;
                  rem_d = rem_q - CNT_W'(1);
               end else begin
                  pc_d    = le_q + PC_W'(1);
                  rem_d   = '0;
                  act_d   = 1'b0;
                  state_d = S_RUN;
               end
            end else begin
               pc_d = pc_q + PC_W'(1);
               if (state_q == S_RUN && cfg_ok) begin
                  state_d = S_LOOP;
                  act_d   = 1'b1;
                  rem_d   = cnt_init(bus.loop_count);
                  ls_d    = bus.loop_start;
                  le_d    = bus.loop_end;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_HALT;
         pc_q    <= '0;
         loop_q  <= 1'b0;
         act_q   <= 1'b0;
         rem_q   <= '0;
         ls_q    <= '0;
         le_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         loop_q  <= 1'b1;
         act_q   <= act_d;
         rem_q   <= rem_d;
         ls_q    <= ls_d;
         le_q    <= le_d;
      end
   end

   fe_valid_pipe #(
      .DEPTH (FE_LAT)
   ) u_vpipe (
      .clk     (CLOCK_50),
      .rst     (reset),
      .clr     (clr),
      .issue_i (issue),
      .valid_o (bus.id_valid)
   );

   assign bus.Loop        = loop_q;
   assign bus.PC_in       = pc_q;
   assign bus.running     = issue;
   assign bus.loop_active = act_q;
   assign bus.loop_remain = rem_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: start, branch,
// loops, halt, PC wrap and async reset.
module tb_fetch_seq_ctrl;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;

   fetch_seq_ctrl_if bus ();

   fetch_seq_ctrl dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus.master)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] hist[$];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   // advance one cycle; outputs sampled on negedge
   task automatic tick();
      @(negedge CLOCK_50);
      hist.push_back(bus.PC_in);
   endtask

   logic [15:0] t3_pc[9];
   logic [7:0]  t3_rem[9];
   logic        t3_act[9];

   initial begin
      t3_pc  = '{16'h21, 16'h22, 16'h20, 16'h21,
                 16'h22, 16'h20, 16'h21, 16'h22,
                 16'h23};
      t3_rem = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd2,
                 8'd1, 8'd1, 8'd1, 8'd0};
      t3_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b0};

      bus.start      = 1'b0;
      bus.start_pc   = '0;
      bus.halt       = 1'b0;
      bus.br_valid   = 1'b0;
      bus.br_target  = '0;
      bus.loop_cfg   = 1'b0;
      bus.loop_start = '0;
      bus.loop_end   = '0;
      bus.loop_count = '0;

      // reset values
      tick();
      chk("rst_Loop", 32'(bus.Loop), 0);
      chk("rst_pc", 32'(bus.PC_in), 0);
      chk("rst_idv", 32'(bus.id_valid), 0);
      chk("rst_run", 32'(bus.running), 0);
      chk("rst_act", 32'(bus.loop_active), 0);
      chk("rst_rem", 32'(bus.loop_remain), 0);
      reset = 1'b0;
      tick();
      chk("halt_run", 32'(bus.running), 0);

      // 1: start at 0x10
      bus.start    = 1'b1;
      bus.start_pc = 16'h10;
      tick();
      bus.start = 1'b0;
      chk("t1_pc0", 32'(bus.PC_in), 32'h10);
      chk("t1_run", 32'(bus.running), 1);
      chk("t1_Loop", 32'(bus.Loop), 1);
      chk("t1_idv0", 32'(bus.id_valid), 0);
      tick();
      chk("t1_pc1", 32'(bus.PC_in), 32'h11);
      chk("t1_idv1", 32'(bus.id_valid), 0);
      tick();
      chk("t1_pc2", 32'(bus.PC_in), 32'h12);
      chk("t1_idv2", 32'(bus.id_valid), 1);
      chk("t1_idpc", 32'(hist[$-2]), 32'h10);

      // 2: branch to 0x40
      bus.br_valid  = 1'b1;
      bus.br_target = 16'h40;
      tick();
      bus.br_valid = 1'b0;
      chk("t2_pc", 32'(bus.PC_in), 32'h40);
      chk("t2_idv1", 32'(bus.id_valid), 0);
      tick();
      chk("t2_idv2", 32'(bus.id_valid), 0);
      tick();
      chk("t2_idv3", 32'(bus.id_valid), 1);
      chk("t2_idpc", 32'(hist[$-2]), 32'h40);

      // 3: loop 0x20..0x22 x3
      bus.br_valid  = 1'b1;
      bus.br_target = 16'h20;
      tick();
      bus.br_valid   = 1'b0;
      bus.loop_cfg   = 1'b1;
      bus.loop_start = 16'h20;
      bus.loop_end   = 16'h22;
      bus.loop_count = 8'd3;
      tick();
      bus.loop_cfg = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick();
         chk($sformatf("t3_pc%0d", i),
             32'(bus.PC_in), 32'(t3_pc[i]));
         chk($sformatf("t3_rem%0d", i),
             32'(bus.loop_remain), 32'(t3_rem[i]));
         chk($sformatf("t3_act%0d", i),
             32'(bus.loop_active), 32'(t3_act[i]));
         chk($sformatf("t3_idv%0d", i),
             32'(bus.id_valid), (i > 0) ? 1 : 0);
      end

      // 4: count 0, 1-slot body at 0x30
      bus.br_valid   = 1'b1;
      bus.br_target  = 16'h2E;
      bus.loop_cfg   = 1'b1;
      bus.loop_start = 16'h30;
      bus.loop_end   = 16'h30;
      bus.loop_count = 8'd0;
      tick();
      bus.br_valid = 1'b0;
      chk("t4_drop", 32'(bus.loop_active), 0);
      tick();
      bus.loop_cfg = 1'b0;
      chk("t4_pc0", 32'(bus.PC_in), 32'h2F);
      chk("t4_act0", 32'(bus.loop_active), 1);
      chk("t4_rem0", 32'(bus.loop_remain), 1);
      tick();
      chk("t4_pc1", 32'(bus.PC_in), 32'h30);
      chk("t4_idv1", 32'(bus.id_valid), 1);
      tick();
      chk("t4_pc2", 32'(bus.PC_in), 32'h31);
      chk("t4_act2", 32'(bus.loop_active), 0);
      chk("t4_rem2", 32'(bus.loop_remain), 0);
      chk("t4_idv2", 32'(bus.id_valid), 1);

      // 5: halt wins over branch
      tick();
      chk("t5_pre", 32'(bus.PC_in), 32'h32);
      bus.halt      = 1'b1;
      bus.br_valid  = 1'b1;
      bus.br_target = 16'h99;
      tick();
      bus.halt     = 1'b0;
      bus.br_valid = 1'b0;
      chk("t5_run", 32'(bus.running), 0);
      chk("t5_pc", 32'(bus.PC_in), 32'h32);
      chk("t5_idv", 32'(bus.id_valid), 0);
      tick();
      chk("t5_pc_h", 32'(bus.PC_in), 32'h32);
      chk("t5_idv_h", 32'(bus.id_valid), 0);
      bus.start    = 1'b1;
      bus.start_pc = 16'h05;
      tick();
      bus.start = 1'b0;
      chk("t5_rs_pc", 32'(bus.PC_in), 32'h05);
      chk("t5_rs_run", 32'(bus.running), 1);
      tick();
      tick();
      chk("t5_rs_pc2", 32'(bus.PC_in), 32'h07);
      chk("t5_rs_idv", 32'(bus.id_valid), 1);
      chk("t5_rs_idpc", 32'(hist[$-2]), 32'h05);

      // 6: wrap, then reset mid-loop
      bus.br_valid  = 1'b1;
      bus.br_target = 16'hFFFE;
      tick();
      bus.br_valid = 1'b0;
      chk("t6_pc0", 32'(bus.PC_in), 32'hFFFE);
      tick();
      chk("t6_pc1", 32'(bus.PC_in), 32'hFFFF);
      tick();
      chk("t6_wrap", 32'(bus.PC_in), 32'h0000);
      bus.loop_cfg   = 1'b1;
      bus.loop_start = 16'h0;
      bus.loop_end   = 16'h5;
      bus.loop_count = 8'd5;
      tick();
      bus.loop_cfg = 1'b0;
      chk("t6_act", 32'(bus.loop_active), 1);
      chk("t6_rem", 32'(bus.loop_remain), 5);
      chk("t6_idv", 32'(bus.id_valid), 1);
      #3 reset = 1'b1;
      #1;
      chk("t6_r_Loop", 32'(bus.Loop), 0);
      chk("t6_r_pc", 32'(bus.PC_in), 0);
      chk("t6_r_idv", 32'(bus.id_valid), 0);
      chk("t6_r_run", 32'(bus.running), 0);
      chk("t6_r_act", 32'(bus.loop_active), 0);
      chk("t6_r_rem", 32'(bus.loop_remain), 0);
      tick();
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
